// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_pkg
//  Description : Shared constants and types for the iterative radix-4 divider.
//                Holds the divider state encoding, handshake levels and
//                the layout of the double-width result bus.
//  Revision    : 1.0  initial release
// ============================================================================
package div_unit_pkg;

   // Divider control states (2-bit encoding)
   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   // Handshake levels
   localparam logic DIV_START     = 1'b1;
   localparam logic DIV_STOP      = 1'b0;
   localparam logic DIV_READY     = 1'b1;
   localparam logic DIV_NOT_READY = 1'b0;

   // Result bus layout: {hi = remainder, lo = quotient}
   localparam int DOUBLE_REG_BUS = 64;
   localparam int HI_ADDR        = 1;
   localparam int LO_ADDR        = 0;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_r4_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_r4_step
//  Description : One radix-4 restoring-division step (combinational).
//                Given the shifted partial remainder r' and the multiples
//                d, 2d, 3d, picks the largest k in {3,2,1,0} with k*d <= r'
//                and returns r' - k*d together with the digit k.
//  Ports       : r_shift_i  partial remainder with 2 new dividend bits
//                d1_i/d2_i/d3_i  divisor multiples 1d, 2d, 3d
//                r_next_o   remainder after the step
//                digit_o    quotient digit k
//  Revision    : 1.0  initial release
// ============================================================================
module div_r4_step
   import div_unit_pkg::*;
#(
   parameter int RW = 34
) (
   input  logic [RW-1:0] r_shift_i,
   input  logic [RW-1:0] d1_i,
   input  logic [RW-1:0] d2_i,
   input  logic [RW-1:0] d3_i,
   output logic [RW-1:0] r_next_o,
   output logic [1:0]    digit_o
);

   // One extra bit on each subtraction: the MSB is the borrow, set when the
   // multiple exceeds the shifted remainder.
   logic [RW:0] diff1_w;
   logic [RW:0] diff2_w;
   logic [RW:0] diff3_w;

   assign diff1_w = {1'b0, r_shift_i} - {1'b0, d1_i};
   assign diff2_w = {1'b0, r_shift_i} - {1'b0, d2_i};
   assign diff3_w = {1'b0, r_shift_i} - {1'b0, d3_i};

   // The largest multiple that does not borrow wins.
   always_comb begin
      r_next_o = r_shift_i;
      digit_o  = 2'd0;
      if (!diff3_w[RW]) begin
         r_next_o = diff3_w[RW-1:0];
         digit_o  = 2'd3;
      end else if (!diff2_w[RW]) begin
         r_next_o = diff2_w[RW-1:0];
         digit_o  = 2'd2;
      end else if (!diff1_w[RW]) begin
         r_next_o = diff1_w[RW-1:0];
         digit_o  = 2'd1;
      end
   end

endmodule : div_r4_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative radix-4 (2 quotient bits per cycle) divider for
//                DIV / DIVU. Operands are latched on start; the result
//                {remainder, quotient} is held with div_ready_o until the
//                initiator drops div_start_i.
//  Ports       : cpu_clk_50M    clock
//                cpu_rst        synchronous active-high reset
//                div_start_i    start request, held until result consumed
//                signed_div_i   1 = signed divide, sampled with start
//                div_opdata1_i  dividend
//                div_opdata2_i  divisor
//                div_annul_i    cancel current operation
//                div_ready_o    result valid
//                div_res_o      {remainder, quotient}
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                cpu_clk_50M,
   input  logic                cpu_rst,
   input  logic                div_start_i,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   div_opdata1_i,
   input  logic [DATA_W-1:0]   div_opdata2_i,
   input  logic                div_annul_i,
   output logic                div_ready_o,
   output logic [2*DATA_W-1:0] div_res_o
);

   localparam int ITER  = DATA_W / 2;
   localparam int CNT_W = $clog2(ITER + 1);
   // Partial remainder width: r' < 4*|d| <= 2^(DATA_W+2)
   localparam int RW    = DATA_W + 2;

   div_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   dvd_q, dvd_d;     // dividend magnitude, shifted out MSB first
   logic [DATA_W-1:0]   quot_q, quot_d;   // accumulated quotient magnitude
   logic [RW-1:0]       rem_q, rem_d;     // partial remainder
   logic [RW-1:0]       d1_q, d1_d;
   logic [RW-1:0]       d2_q, d2_d;
   logic [RW-1:0]       d3_q, d3_d;
   logic                qsign_q, qsign_d;
   logic                rsign_q, rsign_d;
   logic                ready_q, ready_d;
   logic [2*DATA_W-1:0] res_q, res_d;

   logic [DATA_W-1:0]   abs1_w;
   logic [DATA_W-1:0]   abs2_w;
   logic [RW-1:0]       r_shift_w;
   logic [RW-1:0]       r_next_w;
   logic [1:0]          digit_w;
   logic [DATA_W-1:0]   quot_full_w;
   logic [DATA_W-1:0]   rem_mag_w;
   logic [DATA_W-1:0]   quot_fix_w;
   logic [DATA_W-1:0]   rem_fix_w;

   // Magnitudes of the operands; the most negative value maps to its own
   // unsigned magnitude, which fits in DATA_W bits.
   assign abs1_w = (signed_div_i && div_opdata1_i[DATA_W-1]) ? -div_opdata1_i : div_opdata1_i;
   assign abs2_w = (signed_div_i && div_opdata2_i[DATA_W-1]) ? -div_opdata2_i : div_opdata2_i;

   // Bring in the next two dividend bits below the partial remainder.
   assign r_shift_w = (rem_q << 2) | RW'(dvd_q[DATA_W-1 -: 2]);

   div_r4_step #(
      .RW (RW)
   ) u_step (
      .r_shift_i (r_shift_w),
      .d1_i      (d1_q),
      .d2_i      (d2_q),
      .d3_i      (d3_q),
      .r_next_o  (r_next_w),
      .digit_o   (digit_w)
   );

   assign quot_full_w = (quot_q << 2) | DATA_W'(digit_w);
   assign rem_mag_w   = DATA_W'(r_next_w);
   assign quot_fix_w  = qsign_q ? -quot_full_w : quot_full_w;
   assign rem_fix_w   = rsign_q ? -rem_mag_w   : rem_mag_w;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      d3_d    = d3_q;
      qsign_d = qsign_q;
      rsign_d = rsign_q;
      ready_d = ready_q;
      res_d   = res_q;

      case (state_q)
         DIV_FREE: begin
            if (div_start_i == DIV_START) begin
               if (div_opdata2_i == '0) begin
                  state_d = DIV_BYZERO;
               end else begin
                  state_d = DIV_ON;
                  cnt_d   = '0;
                  dvd_d   = abs1_w;
                  quot_d  = '0;
                  rem_d   = '0;
                  d1_d    = RW'(abs2_w);
                  d2_d    = RW'(abs2_w) << 1;
                  d3_d    = RW'(abs2_w) + (RW'(abs2_w) << 1);
                  qsign_d = signed_div_i & (div_opdata1_i[DATA_W-1] ^ div_opdata2_i[DATA_W-1]);
                  rsign_d = signed_div_i & div_opdata1_i[DATA_W-1];
               end
            end
         end

         DIV_BYZERO: begin
            state_d = DIV_END;
            ready_d = DIV_READY;
            res_d   = '0;
         end

         DIV_ON: begin
            dvd_d  = dvd_q << 2;
            rem_d  = r_next_w;
            quot_d = quot_full_w;
            cnt_d  = cnt_q + CNT_W'(1);
            // Last digit: sign-correct and publish on this same edge.
            if (cnt_q == CNT_W'(ITER - 1)) begin
               state_d = DIV_END;
               ready_d = DIV_READY;
               res_d   = {rem_fix_w, quot_fix_w};
            end
         end

         DIV_END: begin
            if (div_start_i == DIV_STOP) begin
               state_d = DIV_FREE;
               ready_d = DIV_NOT_READY;
               res_d   = '0;
            end
         end

         default: begin
            state_d = DIV_FREE;
         end
      endcase

      // Cancel wins over start and over completion.
      if (div_annul_i) begin
         state_d = DIV_FREE;
         ready_d = DIV_NOT_READY;
         res_d   = '0;
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state_q <= DIV_FREE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         d3_q    <= '0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         ready_q <= DIV_NOT_READY;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         d3_q    <= d3_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         ready_q <= ready_d;
         res_q   <= res_d;
      end
   end

   assign div_ready_o = ready_q;
   assign div_res_o   = res_q;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit: directed cases followed
//                by randomized signed/unsigned divides against a plain
//                arithmetic reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sgn;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        annul;
   logic        ready;
   logic [63:0] res;

   int vectors;
   int miscompares;

   div_unit #(
      .DATA_W (32)
   ) dut (
      .cpu_clk_50M   (clk),
      .cpu_rst       (rst),
      .div_start_i   (start),
      .signed_div_i  (sgn),
      .div_opdata1_i (op1),
      .div_opdata2_i (op2),
      .div_annul_i   (annul),
      .div_ready_o   (ready),
      .div_res_o     (res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {remainder, quotient}, truncating division; zero divisor -> 0.
   function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic s);
      longint n, d, q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         n = longint'($signed(a));
         d = longint'($signed(b));
      end else begin
         n = longint'({32'd0, a});
         d = longint'({32'd0, b});
      end
      q = n / d;
      r = n % d;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launch a divide, wait for ready (bounded), check latency and result,
   // optionally check hold behaviour, then release start and check clear.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit check_hold);
      int          edges;
      bit          got;
      logic [63:0] exp;
      exp   = ref_div(a, b, s);
      op1   = a;
      op2   = b;
      sgn   = s;
      start = 1'b1;
      edges = 0;
      got   = 0;
      while (!got && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         if (ready) got = 1;
      end
      chk({tag, "_latency"}, 64'(edges), (b == 32'd0) ? 64'd2 : 64'd17);
      chk({tag, "_res"}, res, exp);
      if (check_hold) begin
         op1 = $urandom;
         op2 = $urandom;
         repeat (2) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, {63'd0, ready}, 64'd1);
            chk({tag, "_hold_res"}, res, exp);
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      if (check_hold) begin
         chk({tag, "_drop_ready"}, {63'd0, ready}, 64'd0);
         chk({tag, "_drop_res"}, res, 64'd0);
      end
   endtask

   initial begin
      logic [31:0] a, b;
      logic        s;
      logic        sr, sd;
      logic [31:0] rr, dd, absr, absd;
      bit          seen;
      vectors     = 0;
      miscompares = 0;
      rst   = 1'b1;
      start = 1'b0;
      sgn   = 1'b0;
      op1   = '0;
      op2   = '0;
      annul = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", {63'd0, ready}, 64'd0);
      chk("reset_res", res, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1. basic unsigned
      run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b1);
      chk("divu_100_7_const", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);

      // 2. signed sign handling
      run_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1);
      run_div("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b1);

      // 3. divide by zero
      run_div("div0_s", 32'h1234, 32'd0, 1'b1, 1'b1);
      run_div("div0_u", 32'h1234, 32'd0, 1'b0, 1'b1);

      // 4. extremes
      run_div("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
      run_div("div_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
      run_div("divu_5_max", 32'd5, 32'hFFFFFFFF, 1'b0, 1'b1);

      // 5a. operand changes during ON are ignored
      op1 = 32'd1000; op2 = 32'd7; sgn = 1'b0; start = 1'b1;
      @(posedge clk); #1;                 // E0
      repeat (3) @(posedge clk);
      #1;
      op1 = $urandom; op2 = $urandom; sgn = 1'b1;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (ready) seen = 1;
      end
      chk("latch_ready", {63'd0, ready}, 64'd1);
      chk("latch_res", res, ref_div(32'd1000, 32'd7, 1'b0));
      start = 1'b0;
      @(posedge clk); #1;

      // 5b. annul mid-operation
      op1 = 32'd12345; op2 = 32'd3; sgn = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1;
      annul = 1'b1;
      @(posedge clk); #1;
      annul = 1'b0;
      start = 1'b0;
      chk("annul_ready", {63'd0, ready}, 64'd0);
      chk("annul_res", res, 64'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (ready) seen = 1;
      end
      chk("annul_no_ready", {63'd0, seen}, 64'd0);
      run_div("after_annul_91_10", 32'd91, 32'd10, 1'b0, 1'b1);

      // 6a. reset mid-operation
      op1 = 32'd999999; op2 = 32'd13; sgn = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_mid_ready", {63'd0, ready}, 64'd0);
      chk("rst_mid_res", res, 64'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (ready) seen = 1;
      end
      chk("rst_no_ready", {63'd0, seen}, 64'd0);

      // 6b. randomized run
      for (int n = 0; n < 2000; n++) begin
         a = $urandom;
         b = $urandom;
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: b = $urandom_range(0, 15);
            1: b = 32'hFFFFFFFF - $urandom_range(0, 3);
            2: a = 32'h80000000;
            3: b = b >> $urandom_range(1, 31);
            default: ;
         endcase
         run_div("rand", a, b, s, 1'b0);
         if (b != 32'd0) begin
            // remainder bound in magnitude
            rr   = ref_div(a, b, s) >> 32;
            sr   = s & rr[31];
            sd   = s & b[31];
            absr = sr ? -rr : rr;
            absd = sd ? -b : b;
            chk("rand_bound", {63'd0, (absr < absd)}, 64'd1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_div_unit
`default_nettype wire
